// File: rtl/spi_burst_master.sv
// spi_burst_master: SPI master engine with configurable word width, several
// chip selects, all four CPOL/CPHA modes and multi-word bursts. TX words
// arrive on a valid/ready stream and RX words leave as one-cycle strobes.
// The active chip select stays low across every word of a burst. A stalled
// TX stream freezes SCLK at its idle level without releasing the chip select.

module spi_burst_master #(
    parameter int DATA_W = 8,   // bits per SPI word, MSB first (>= 2)
    parameter int CS_NUM = 4,   // number of chip-select outputs (>= 2)
    parameter int CNT_W  = 8,   // width of burst word counter
    parameter int DIV_W  = 16   // width of clock divider
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    input  logic                      cfg_cpol,
    input  logic                      cfg_cpha,
    input  logic [$clog2(CS_NUM)-1:0] cfg_cs_sel,
    input  logic [CNT_W-1:0]          cfg_word_num,
    input  logic [DIV_W-1:0]          clk_div,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_valid,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic [CS_NUM-1:0]         cs_n
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // One SCLK edge per half-period tick; a word takes 2*DATA_W ticks.
    localparam int                EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    logic [2:0]                state_q,    state_d;
    logic                      busy_q,     busy_d;
    logic                      cpol_q,     cpol_d;
    logic                      cpha_q,     cpha_d;
    logic [$clog2(CS_NUM)-1:0] cs_sel_q,   cs_sel_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [DIV_W-1:0]          div_q,      div_d;
    logic [DIV_W-1:0]          tick_cnt_q, tick_cnt_d;
    logic [EDGE_W-1:0]         edge_cnt_q, edge_cnt_d;
    logic                      first_q,    first_d;
    logic [DATA_W-1:0]         shift_q,    shift_d;
    logic [DATA_W-1:0]         rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]         rx_data_q,  rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      sclk_q,     sclk_d;
    logic                      mosi_q,     mosi_d;
    logic [CS_NUM-1:0]         cs_n_q,     cs_n_d;

    logic tick;
    logic leading;
    logic last_edge;

    // Half-period tick: the counter runs from 0 up to the latched divider.
    assign tick      = (tick_cnt_q == div_q);
    // Even-numbered edges move SCLK away from its idle level.
    assign leading   = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == LAST_EDGE);

    // A word is consumed on the cycle LOAD sees it valid.
    assign tx_ready = (state_q == ST_LOAD) && tx_valid;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

    // Next-state logic: burst sequencing, SCLK edges and the data shifters.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path leaves it unassigned (no latches).
        state_d    = state_q;
        busy_d     = busy_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cs_sel_d   = cs_sel_q;
        word_cnt_d = word_cnt_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        first_d    = first_q;
        shift_d    = shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;

        // The divider only runs in the timed states and restarts after every tick.
        if (tick || state_q == ST_IDLE || state_q == ST_LOAD) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                if (start) begin
                    // Configuration is frozen here for the whole burst.
                    cpol_d     = cfg_cpol;
                    cpha_d     = cfg_cpha;
                    cs_sel_d   = cfg_cs_sel;
                    word_cnt_d = cfg_word_num;
                    div_d      = clk_div;
                    first_d    = 1'b1;
                    busy_d     = 1'b1;
                    sclk_d     = cfg_cpol;
                    state_d    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                sclk_d = cpol_q;
                if (tx_valid) begin
                    shift_d    = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    edge_cnt_d = '0;
                    if (first_q) begin
                        first_d = 1'b0;
                        cs_n_d  = ~(CS_NUM'(1) << cs_sel_q);
                        state_d = ST_SETUP;
                    end else begin
                        // Chip select is already low from the previous word.
                        state_d = ST_SHIFT;
                    end
                end else if (stop) begin
                    cs_n_d  = '1;
                    state_d = ST_DONE;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    if (leading) begin
                        if (!cpha_q) begin
                            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                        end else if (edge_cnt_q != '0) begin
                            // CPHA=1: the MSB is already on MOSI for the first leading edge.
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            mosi_d  = shift_q[DATA_W-2];
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                        end else if (!last_edge) begin
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            mosi_d  = shift_q[DATA_W-2];
                        end
                    end
                    if (last_edge) begin
                        edge_cnt_d = '0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_d;
                        state_d    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    if (word_cnt_q != '0 && !stop) begin
                        word_cnt_d = word_cnt_q - CNT_W'(1);
                        state_d    = ST_LOAD;
                    end else begin
                        cs_n_d  = '1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Minimum chip-select-high gap before another burst can start.
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cs_n_d  = '1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset returns all outputs to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_sel_q   <= '0;
            word_cnt_q <= '0;
            div_q      <= '0;
            tick_cnt_q <= '0;
            edge_cnt_q <= '0;
            first_q    <= 1'b0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            busy_q     <= busy_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cs_sel_q   <= cs_sel_d;
            word_cnt_q <= word_cnt_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            first_q    <= first_d;
            shift_q    <= shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: an 8-bit instance in MISO loopback and a
// 12-bit instance talking to a small mode-0 slave model. Expected RX words go
// into scoreboard queues when stimulus is issued; monitors pop them on rx_valid.

module tb_spi_burst_master;

    logic clk;
    logic rst;

    // 8-bit instance, MISO looped back from MOSI
    logic        start, stop, busy;
    logic        cfg_cpol, cfg_cpha;
    logic [1:0]  cfg_cs_sel;
    logic [7:0]  cfg_word_num;
    logic [15:0] clk_div;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sclk, mosi, miso;
    logic [3:0]  cs_n;

    // 12-bit instance, clk_div = 0, mode 0
    logic        start_w, stop_w, busy_w;
    logic        cfg_cpol_w, cfg_cpha_w;
    logic [1:0]  cfg_cs_sel_w;
    logic [7:0]  cfg_word_num_w;
    logic [15:0] clk_div_w;
    logic [11:0] tx_data_w;
    logic        tx_valid_w, tx_ready_w;
    logic [11:0] rx_data_w;
    logic        rx_valid_w;
    logic        sclk_w, mosi_w, miso_w;
    logic [3:0]  cs_n_w;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q   [$];
    logic [11:0] exp_q_w [$];
    logic [7:0]  words   [16];

    int  rx_seen = 0, rdy_seen = 0, rise_cnt = 0;
    time last_rise = 0, period = 0;
    int  rx_seen_w = 0, edges_w = 0;
    time last_rise_w = 0, period_w = 0;

    logic [11:0] slave_pat = 12'hB34;
    logic [11:0] slave_rx  = '0;
    int          slave_idx = 0;

    assign miso   = mosi;
    assign miso_w = (slave_idx < 12) ? slave_pat[11 - slave_idx] : 1'b0;

    spi_burst_master #(.DATA_W(8), .CS_NUM(4), .CNT_W(8), .DIV_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_cs_sel(cfg_cs_sel),
        .cfg_word_num(cfg_word_num), .clk_div(clk_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_burst_master #(.DATA_W(12), .CS_NUM(4), .CNT_W(8), .DIV_W(16)) u_dut_w (
        .clk(clk), .rst(rst), .start(start_w), .stop(stop_w), .busy(busy_w),
        .cfg_cpol(cfg_cpol_w), .cfg_cpha(cfg_cpha_w), .cfg_cs_sel(cfg_cs_sel_w),
        .cfg_word_num(cfg_word_num_w), .clk_div(clk_div_w),
        .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready_w),
        .rx_data(rx_data_w), .rx_valid(rx_valid_w),
        .sclk(sclk_w), .mosi(mosi_w), .miso(miso_w), .cs_n(cs_n_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the 8-bit instance; also counts tx_ready pulses.
    initial begin : mon8
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_ready) rdy_seen++;
            if (rx_valid) begin
                rx_seen++;
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e});
                end
            end
        end
    end

    // Scoreboard monitor for the 12-bit instance.
    initial begin : mon12
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid_w) begin
                rx_seen_w++;
                if (exp_q_w.size() == 0) begin
                    check("rx_w_unexpected", {20'd0, rx_data_w}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q_w.pop_front();
                    check("rx_data_w", {20'd0, rx_data_w}, {20'd0, e});
                end
            end
        end
    end

    initial begin : sclk_mon
        forever begin
            @(posedge sclk);
            rise_cnt++;
            period    = $time - last_rise;
            last_rise = $time;
        end
    end

    initial begin : sclk_w_mon
        forever begin
            @(sclk_w);
            edges_w++;
            if (sclk_w) begin
                period_w    = $time - last_rise_w;
                last_rise_w = $time;
            end
        end
    end

    // Mode-0 slave on cs_n_w[0]: MISO advances after each rising edge, MOSI captured on it.
    initial begin : slave_model
        forever begin
            @(negedge cs_n_w[0] or posedge sclk_w);
            if (!cs_n_w[0] && sclk_w) begin
                slave_rx  = {slave_rx[10:0], mosi_w};
                slave_idx = slave_idx + 1;
            end else if (!cs_n_w[0]) begin
                slave_idx = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one burst on the 8-bit instance; pushes each accepted word as the expected RX word.
    task automatic run_burst(input logic cpol, input logic cpha, input logic [1:0] cs_sel,
                             input logic [15:0] div, input int n_words, input int stop_after,
                             input int stall_idx, input int exp_words, input string tag);
        int         accepted = 0;
        int         cyc = 0;
        int         stall_cnt = 0;
        int         cs_rise = 0;
        int         bad_cs = 0;
        int         frozen_rise = 0;
        int         rise0, rdy0, rx0;
        logic       stalling;
        logic       done = 1'b0;
        logic [3:0] exp_cs;
        logic [3:0] prev_cs;
        exp_cs       = ~(4'b0001 << cs_sel);
        cfg_cpol     = cpol;
        cfg_cpha     = cpha;
        cfg_cs_sel   = cs_sel;
        cfg_word_num = 8'(n_words - 1);
        clk_div      = div;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        rise0   = rise_cnt;
        rdy0    = rdy_seen;
        rx0     = rx_seen;
        prev_cs = cs_n;
        while (cyc < 5000) begin
            stalling = (accepted == stall_idx) && (stall_cnt < 50);
            tx_valid = (accepted < n_words) && !stalling;
            if (accepted < n_words) tx_data = words[accepted];
            stop = (stop_after >= 0) && (accepted >= stop_after);
            @(negedge clk);
            cyc++;
            if (stalling) begin
                stall_cnt++;
                if (stall_cnt == 40) frozen_rise = rise_cnt;
                if (stall_cnt == 50) begin
                    check({tag, "_stall_cs_low"}, {28'd0, cs_n}, {28'd0, exp_cs});
                    check({tag, "_stall_sclk_idle"}, {31'd0, sclk}, {31'd0, cpol});
                    check({tag, "_stall_sclk_frozen"}, rise_cnt, frozen_rise);
                    check({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
                end
            end
            if (cs_n != 4'hF && cs_n != exp_cs) bad_cs++;
            if (prev_cs != 4'hF && cs_n == 4'hF) cs_rise++;
            prev_cs = cs_n;
            if (tx_ready) begin
                exp_q.push_back(words[accepted]);
                accepted++;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        stop     = 1'b0;
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        check({tag, "_tx_ready_pulses"}, rdy_seen - rdy0, exp_words);
        check({tag, "_rx_valid_pulses"}, rx_seen - rx0, exp_words);
        check({tag, "_sclk_rises"}, rise_cnt - rise0, 8 * exp_words);
        check({tag, "_other_cs_quiet"}, bad_cs, 0);
        check({tag, "_cs_single_release"}, cs_rise, 1);
        check({tag, "_cs_idle"}, {28'd0, cs_n}, 32'hF);
        check({tag, "_sclk_idle"}, {31'd0, sclk}, {31'd0, cpol});
    endtask

    initial begin : stimulus
        logic got;
        int   rx0, edges0;
        rst = 1'b1;
        start = 0; stop = 0; cfg_cpol = 0; cfg_cpha = 0; cfg_cs_sel = 0;
        cfg_word_num = 0; clk_div = 0; tx_data = 0; tx_valid = 0;
        start_w = 0; stop_w = 0; cfg_cpol_w = 0; cfg_cpha_w = 0; cfg_cs_sel_w = 0;
        cfg_word_num_w = 0; clk_div_w = 0; tx_data_w = 0; tx_valid_w = 0;
        foreach (words[i]) words[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_cs_n", {28'd0, cs_n}, 32'hF);
        check("rst_cs_n_w", {28'd0, cs_n_w}, 32'hF);
        @(posedge clk); #1 rst = 1'b0;

        // 1: mode 0, div 4, single word 0xA5
        words[0] = 8'hA5;
        run_burst(1'b0, 1'b0, 2'd0, 16'd4, 1, -1, -1, 1, "t1");
        check("t1_sclk_period_ns", 32'(period), 32'd100);

        // 2: mode 3, cs 2, four-word burst
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; words[3] = 8'h78;
        run_burst(1'b1, 1'b1, 2'd2, 16'd2, 4, -1, -1, 4, "t2");
        repeat (20) @(negedge clk);
        check("t2_sclk_idles_high", {31'd0, sclk}, 32'd1);

        // 3: stall 50 cycles before the second word
        words[0] = 8'h3C; words[1] = 8'hC3;
        run_burst(1'b0, 1'b0, 2'd1, 16'd1, 2, -1, 1, 2, "t3");

        // 4: stop raised during word 2 of a ten-word burst
        for (int i = 0; i < 10; i++) words[i] = 8'(8'h81 + 8'(i * 7));
        run_burst(1'b0, 1'b0, 2'd3, 16'd1, 10, 2, -1, 2, "t4");

        // 5: start while busy is ignored; reset mid-SHIFT
        @(posedge clk); #1;
        cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_cs_sel = 2'd0; cfg_word_num = 8'd0; clk_div = 16'd3;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h9E;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1'b1;
        end
        check("t5_word_accepted", {31'd0, got}, 32'd1);
        @(posedge clk); #1 tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 cfg_cs_sel = 2'd3; cfg_cpol = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_restart_ignored_cs", {28'd0, cs_n}, 32'hE);
        check("t5_still_busy", {31'd0, busy}, 32'd1);
        rx0 = rx_seen;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("t5_rst_cs_n", {28'd0, cs_n}, 32'hF);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_sclk", {31'd0, sclk}, 32'd0);
        check("t5_rst_mosi", {31'd0, mosi}, 32'd0);
        check("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t5_no_rx_after_rst", rx_seen - rx0, 0);
        check("t5_idle_after_rst", {31'd0, busy}, 32'd0);

        // 6: 12-bit instance, clk_div 0, slave pattern 0xB34
        edges0 = edges_w;
        rx0    = rx_seen_w;
        @(posedge clk); #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        tx_valid_w = 1'b1; tx_data_w = 12'h5C3;
        exp_q_w.push_back(12'hB34);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tx_ready_w) got = 1'b1;
        end
        check("t6_word_accepted", {31'd0, got}, 32'd1);
        @(posedge clk); #1 tx_valid_w = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!busy_w) got = 1'b1;
        end
        check("t6_completed", {31'd0, got}, 32'd1);
        check("t6_sclk_edges", edges_w - edges0, 24);
        check("t6_sclk_period_ns", 32'(period_w), 32'd20);
        check("t6_rx_valid_pulses", rx_seen_w - rx0, 1);
        check("t6_slave_saw_mosi", {20'd0, slave_rx}, 32'h5C3);
        check("t6_cs_idle", {28'd0, cs_n_w}, 32'hF);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("scoreboard_w_drained", exp_q_w.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
